// File: rtl/iecdrv_rom_sched_pkg.sv
// Shared types and helpers for the multi-drive ROM time-slot scheduler.
// When IECDRV_ROMSCHED_WR_EN is defined the state set includes the loader WRITE state.
package iecdrv_rom_pkg;

    localparam int ROM_AW = 15;

    localparam logic [1:0] ROM_SZ_8K  = 2'b00;
    localparam logic [1:0] ROM_SZ_16K = 2'b01;
    localparam logic [1:0] ROM_SZ_32K = 2'b11;

`ifdef IECDRV_ROMSCHED_WR_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE} rom_sched_state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} rom_sched_state_t;
`endif

    // Mirror smaller ROM images: A14 only exists for 32K, A13 for 16K/32K or the standard ROM.
    function automatic logic [ROM_AW-1:0] rom_fold(input logic [ROM_AW-1:0] addr,
                                                   input logic [1:0]        rom_sz,
                                                   input logic              stdrom);
        logic [ROM_AW-1:0] f;
        f     = addr;
        f[14] = addr[14] & rom_sz[1];
        f[13] = addr[13] & (rom_sz[0] | stdrom);
        return f;
    endfunction

endpackage

// File: rtl/iecdrv_rom_sched_if.sv
// Shared ROM port bundle. With IECDRV_ROMSCHED_WR_EN the write side is carried too.
interface iecdrv_rom_sched_if #(parameter int AW = 15);
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_q;
`ifdef IECDRV_ROMSCHED_WR_EN
    logic          rom_we;
    logic [7:0]    rom_wdata;
    modport master (output rom_addr, rom_we, rom_wdata, input rom_q);
    modport slave  (input rom_addr, rom_we, rom_wdata, output rom_q);
`else
    modport master (output rom_addr, input rom_q);
    modport slave  (input rom_addr, output rom_q);
`endif
endinterface

// File: rtl/iecdrv_rom_sched_capture.sv
// Slot-tag / valid delay line matching the ROM latency; writes rom_q into the
// owning drive's data register. A flush drops every in-flight tag, including
// the one that would be captured this cycle.
module iecdrv_rom_capture #(
    parameter int NDR     = 2,
    parameter int ROM_LAT = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           issue_i,
    input  logic [1:0]     slot_i,
    input  logic           last_i,
    input  logic           flush_i,
    input  logic [7:0]     rom_q_i,
    output logic [7:0]     drv_data_o [NDR],
    output logic [NDR-1:0] drv_upd_o,
    output logic           done_o,
    output logic           last_o
);
    localparam int STAGES = ROM_LAT;

    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] last_pipe;
    logic [1:0]      slot_pipe [STAGES+1];
    logic            cap;

    assign cap    = vld_pipe[STAGES] & ~flush_i;
    // Raw (unflushed) view so the FSM can leave DRAIN without a path through flush.
    assign last_o = vld_pipe[STAGES] & last_pipe[STAGES];

    // Tag shift register: stage 0 aligns with rom_addr, stage STAGES with rom_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            for (int j = 0; j <= STAGES; j++) slot_pipe[j] <= 2'd0;
        end else begin
            vld_pipe[0]  <= issue_i;
            last_pipe[0] <= last_i;
            slot_pipe[0] <= slot_i;
            for (int j = 1; j <= STAGES; j++) begin
                vld_pipe[j]  <= vld_pipe[j-1] & ~flush_i;
                last_pipe[j] <= last_pipe[j-1];
                slot_pipe[j] <= slot_pipe[j-1];
            end
        end
    end

    // Capture into the tagged drive register with a coincident update pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NDR; i++) drv_data_o[i] <= 8'hFF;
            drv_upd_o <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o <= cap & last_pipe[STAGES];
            for (int i = 0; i < NDR; i++) begin
                drv_upd_o[i] <= cap && (slot_pipe[STAGES] == 2'(i));
                if (cap && (slot_pipe[STAGES] == 2'(i))) drv_data_o[i] <= rom_q_i;
            end
        end
    end

endmodule

// File: rtl/iecdrv_rom_sched.sv
// Time-slot scheduler sharing one ROM port among NDR drive cores. Each ph2_f
// launches a fetch frame that issues one folded address per slot; loader writes
// (IECDRV_ROMSCHED_WR_EN) use the IDLE gaps between frames.
module iecdrv_rom_sched
    import iecdrv_rom_pkg::*;
#(
    parameter int NDR     = 2,
    parameter int AW      = 15,
    parameter int ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ph2_f,
    input  logic [1:0]         rom_sz,
    input  logic               stdrom,
    input  logic [AW-1:0]      drv_addr [NDR],
    output logic [7:0]         drv_data [NDR],
    output logic [NDR-1:0]     drv_upd,
    iecdrv_rom_sched_if.master rom,
    output logic               frame_done,
    output logic               overrun
`ifdef IECDRV_ROMSCHED_WR_EN
    ,
    input  logic               wr_req,
    input  logic [AW-1:0]      wr_addr,
    input  logic [7:0]         wr_data,
    output logic               wr_ack
`endif
);
    rom_sched_state_t state_q, state_d;
    logic [1:0]       slot_q, slot_d;       // next slot to issue while in FETCH
    logic [AW-1:0]    addr_q, addr_d;
    logic             ovr_q, ovr_d;
    logic             issue, flush, cap_last;
    logic [1:0]       issue_slot;
    logic [AW-1:0]    sel_addr;
`ifdef IECDRV_ROMSCHED_WR_EN
    logic             we_q, we_d, ack_q, ack_d;
    logic [7:0]       wdata_q, wdata_d;
`endif

    // Next state: ph2_f always (re)starts at slot 0 and issues it this cycle.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        addr_d     = addr_q;
        ovr_d      = ovr_q;
        issue      = 1'b0;
        issue_slot = slot_q;
        flush      = 1'b0;
        sel_addr   = '0;
`ifdef IECDRV_ROMSCHED_WR_EN
        we_d       = 1'b0;
        ack_d      = 1'b0;
        wdata_d    = wdata_q;
`endif
        if (ph2_f) begin
            issue      = 1'b1;
            issue_slot = 2'd0;
            slot_d     = 2'd1;
            state_d    = (NDR == 1) ? S_DRAIN : S_FETCH;
            if (state_q == S_FETCH || state_q == S_DRAIN) begin
                ovr_d = 1'b1;
                flush = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    issue  = 1'b1;
                    slot_d = slot_q + 2'd1;
                    if (slot_q == 2'(NDR-1)) state_d = S_DRAIN;
                end
                S_DRAIN: if (cap_last) state_d = S_IDLE;
`ifdef IECDRV_ROMSCHED_WR_EN
                S_WRITE: state_d = S_IDLE;
                S_IDLE: if (wr_req) begin
                    state_d = S_WRITE;
                    addr_d  = wr_addr;
                    we_d    = 1'b1;
                    ack_d   = 1'b1;
                    wdata_d = wr_data;
                end
`else
                S_IDLE: ;
`endif
                default: state_d = S_IDLE;
            endcase
        end
        if (issue) begin
            for (int i = 0; i < NDR; i++)
                if (issue_slot == 2'(i)) sel_addr = drv_addr[i];
            addr_d = AW'(rom_fold(ROM_AW'(sel_addr), rom_sz, stdrom));
        end
    end

    // State, slot counter, registered ROM address and sticky overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            slot_q  <= 2'd0;
            addr_q  <= '0;
            ovr_q   <= 1'b0;
`ifdef IECDRV_ROMSCHED_WR_EN
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            wdata_q <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            addr_q  <= addr_d;
            ovr_q   <= ovr_d;
`ifdef IECDRV_ROMSCHED_WR_EN
            we_q    <= we_d;
            ack_q   <= ack_d;
            wdata_q <= wdata_d;
`endif
        end
    end

    assign rom.rom_addr = addr_q;
    assign overrun      = ovr_q;
`ifdef IECDRV_ROMSCHED_WR_EN
    assign rom.rom_we    = we_q;
    assign rom.rom_wdata = wdata_q;
    assign wr_ack        = ack_q;
`endif

    iecdrv_rom_capture #(.NDR(NDR), .ROM_LAT(ROM_LAT)) u_cap (
        .clk        (clk),
        .reset_n    (reset_n),
        .issue_i    (issue),
        .slot_i     (issue_slot),
        .last_i     (issue_slot == 2'(NDR-1)),
        .flush_i    (flush),
        .rom_q_i    (rom.rom_q),
        .drv_data_o (drv_data),
        .drv_upd_o  (drv_upd),
        .done_o     (frame_done),
        .last_o     (cap_last)
    );

endmodule
